// File: rtl/alu_cmd_issuer.sv
// Initiator for a combinational ALU: accepts one command at a time and drives the ALU from registered operands.
// It registers the ALU result, returns it on a valid/ready response channel and keeps it as an accumulator.
module alu_cmd_issuer #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [2:0]       cmd_sel,
  input  logic             cmd_use_acc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_sel,
  input  logic [W-1:0]     alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [2:0]       rsp_sel,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [W-1:0]     alu_a_q;
  logic [W-1:0]     alu_b_q;
  logic [2:0]       alu_sel_q;
  logic [W-1:0]     rsp_data_q;
  logic [2:0]       rsp_sel_q;
  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] ops_done_q;

  logic [W-1:0]     alu_a_d;
  logic [CNT_W-1:0] ops_done_d;
  logic             cmd_fire;
  logic             rsp_fire;

  // Chained commands take operand A from the accumulator, which is already updated by the time IDLE returns.
  assign alu_a_d    = cmd_use_acc ? acc_q : cmd_a;
  assign ops_done_d = ops_done_q + CNT_W'(1);
  assign cmd_fire   = cmd_valid & cmd_ready_q;
  assign rsp_fire   = rsp_valid_q & rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 3'b000;
      rsp_data_q  <= '0;
      rsp_sel_q   <= 3'b000;
      acc_q       <= '0;
      ops_done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= cmd_b;
            alu_sel_q   <= cmd_sel;
            cmd_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has had a full cycle on stable operands; capture its result.
          rsp_data_q  <= alu_out;
          rsp_sel_q   <= alu_sel_q;
          acc_q       <= alu_out;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            ops_done_q  <= ops_done_d;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sel   = rsp_sel_q;
  assign acc       = acc_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU on the ALU ports, table vectors, corner sequences and random traffic.
// The counter is built narrower here so its wrap can be reached in a short run.
module tb_alu_cmd_issuer;
  localparam int W       = 8;
  localparam int CNT_W   = 10;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int DMOD    = 1 << W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [W-1:0]     cmd_a = '0;
  logic [W-1:0]     cmd_b = '0;
  logic [2:0]       cmd_sel = 3'b000;
  logic             cmd_use_acc = 1'b0;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [2:0]       alu_sel;
  logic [W-1:0]     alu_out;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_data;
  logic [2:0]       rsp_sel;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] ops_done;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [W-1:0] m_acc;
  int           m_ops;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sel(rsp_sel), .acc(acc), .ops_done(ops_done)
  );

  // ALU behaviour from the opcode table, in plain integer arithmetic.
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] sel);
    int ai, bi, sh, r;
    ai = int'(a);
    bi = int'(b);
    sh = bi % 8;
    case (sel)
      3'd0:    r = (ai + bi) % DMOD;
      3'd1:    r = (ai - bi + DMOD) % DMOD;
      3'd2:    r = (ai * (1 << sh)) % DMOD;
      3'd3:    r = ai / (1 << sh);
      3'd4:    r = int'(a & b);
      3'd5:    r = int'(a | b);
      3'd6:    r = int'(a ^ b);
      default: r = (ai == bi) ? 1 : 0;
    endcase
    return W'(r);
  endfunction

  always_comb alu_out = alu_ref(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    m_ops = 0;
    @(negedge clk);
  endtask

  // One full command: accept, EXEC, RESP with `stall` extra cycles of backpressure, handshake.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                       input logic ua, input int stall, input logic hold, input logic [W-1:0] exp);
    logic [W-1:0] ea;
    int w;
    ea = ua ? m_acc : a;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_use_acc = ua; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", w, 0);
    if (w >= 50) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold) begin
      cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_sel = 3'($urandom); cmd_use_acc = 1'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    rsp_ready = (stall == 0);
    chk("exec_cmd_ready", cmd_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, b);
    chk("alu_sel", alu_sel, sel);
    @(negedge clk);
    chk("rsp_valid_lat2", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_sel", rsp_sel, sel);
    chk("acc", acc, exp);
    chk("resp_cmd_ready", cmd_ready, 0);
    m_acc = exp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, exp);
      chk("bp_rsp_sel", rsp_sel, sel);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_alu_a_hold", alu_a, ea);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    m_ops = (m_ops + 1) % CNT_MOD;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("ops_done", ops_done, m_ops);
    chk("post_cmd_ready", cmd_ready, 1);
    txn++;
    $display("txn %0d: sel=%0d a=%02h b=%02h use_acc=%0b stall=%0d -> data=%02h (exp %02h) ops=%0d",
             txn, sel, ea, b, ua, stall, rsp_data, exp, ops_done);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         ua;
    int           stall;
    logic         hold;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] ra, rb, re;
    logic [2:0]   rs;
    logic         ru, rh;
    int           rst_stall;

    vecs[0]  = '{8'hF0, 8'h20, 3'b000, 1'b0, 0, 1'b0, 8'h10};
    vecs[1]  = '{8'h05, 8'h07, 3'b001, 1'b0, 0, 1'b0, 8'hFE};
    vecs[2]  = '{8'hAA, 8'h01, 3'b011, 1'b1, 0, 1'b0, 8'h7F};
    vecs[3]  = '{8'h3C, 8'h3C, 3'b111, 1'b0, 5, 1'b1, 8'h01};
    vecs[4]  = '{8'h3C, 8'h3D, 3'b111, 1'b0, 0, 1'b0, 8'h00};
    vecs[5]  = '{8'h81, 8'h09, 3'b010, 1'b0, 1, 1'b0, 8'h02};
    vecs[6]  = '{8'hF0, 8'h3C, 3'b100, 1'b0, 0, 1'b0, 8'h30};
    vecs[7]  = '{8'hF0, 8'h0F, 3'b101, 1'b0, 2, 1'b1, 8'hFF};
    vecs[8]  = '{8'hAA, 8'hFF, 3'b110, 1'b0, 0, 1'b0, 8'h55};
    vecs[9]  = '{8'h00, 8'hAB, 3'b000, 1'b1, 0, 1'b0, 8'h00};
    vecs[10] = '{8'h00, 8'h01, 3'b001, 1'b0, 0, 1'b0, 8'hFF};
    vecs[11] = '{8'h12, 8'h07, 3'b010, 1'b1, 0, 1'b0, 8'h80};

    // Reset state.
    do_reset(2);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_sel", rsp_sel, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Reset during EXEC, then during RESP: the in-flight result is dropped.
    for (int k = 0; k < 2; k++) begin
      cmd_a = 8'h11; cmd_b = 8'h22; cmd_sel = 3'b000; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("midrst_accepted", cmd_ready, 0);
      if (k == 1) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = '0;
      m_ops = 0;
      rsp_ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_acc", acc, 0);
        chk("midrst_ops_done", ops_done, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
      end
      $display("mid-op reset %0d: rsp_valid=%0b acc=%02h ops=%0d", k, rsp_valid, acc, ops_done);
    end

    // Table vectors: opcodes, wraps, chaining, backpressure with the next command held.
    do_reset(2);
    for (int i = 0; i < 12; i++)
      issue(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].ua, vecs[i].stall, vecs[i].hold, vecs[i].exp);

    // Idle: nothing accepted, ALU ports hold the last operands.
    repeat (3) begin
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_alu_sel", alu_sel, 3'b010);
      chk("idle_alu_a", alu_a, 8'hFF);
    end

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 3'($urandom); ru = 1'($urandom);
      rst_stall = $urandom_range(0, 3);
      rh = (i != 149) && ($urandom_range(0, 1) == 1);
      re = alu_ref(ru ? m_acc : ra, rb, rs);
      issue(ra, rb, rs, ru, rst_stall, rh, re);
    end

    // Counter wrap: fill to all-ones, then one more handshake.
    do_reset(2);
    for (int i = 0; i < CNT_MOD - 1; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 3'($urandom);
      issue(ra, rb, rs, 1'b0, 0, 1'b0, alu_ref(ra, rb, rs));
    end
    chk("ops_all_ones", ops_done, CNT_MOD - 1);
    issue(8'h01, 8'h01, 3'b000, 1'b0, 0, 1'b0, 8'h02);
    chk("ops_wrap", ops_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
